phase_decoder: RTL and testbench
================================

# phase_decoder

Consumer end of the S-Machine sequencing interface. The state machine publishes an 8-bit phase `count` under `enable`. `phase_decoder` turns that count into registered per-phase control strobes for the datapath. It also runs the memory request/acknowledge handshake for the fetch and writeback phases, and stalls the state machine through `hold` until memory responds. It checks that the count sequence is legal, counts retired instructions, and latches a sticky fault on any protocol violation.

## Interface
- `NUM_PHASES`, default 4: legal count values are 0..NUM_PHASES-1. Phase 0 = fetch, 1 = decode, 2 = execute, NUM_PHASES-1 = writeback.
- `MEM_TIMEOUT`, default 15: maximum cycles `mem_req` may stay high without `mem_ack`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  same enable that drives the state machine; low = CPU idle.
- `count`  in  8  phase count from the state machine.
- `mem_ack`  in  1  single-cycle memory acknowledge.
- `fetch_en`, `decode_en`, `execute_en`, `writeback_en`  out  1 each  registered phase strobes.
- `mem_req`  out  1  registered memory request.
- `hold`  out  1  combinational stall to the state machine; high = state machine must not advance.
- `retired`  out  16  completed-instruction counter.
- `fault`  out  1  sticky protocol fault.

## Operation
- FSM states:
  - IDLE: reset state.
  - TRACK: normal decoding.
  - MEM_WAIT: `mem_req` outstanding.
  - FAULT: terminal until reset.
- IDLE -> TRACK when `enable`=1 and `count`=0. `enable`=1 with `count`!=0 -> FAULT.
- TRACK / MEM_WAIT -> IDLE when `enable`=0. Strobes and `mem_req` clear; `retired` is kept.
- Memory phases are count 0 and count NUM_PHASES-1. The first sampled cycle of a memory phase -> MEM_WAIT with `mem_req`=1. MEM_WAIT -> TRACK on the edge where `mem_ack`=1, with `mem_req`=0 next cycle.
- `hold` = enable & memory-phase(count) & !(mem_req & mem_ack) & state!=IDLE, OR state==FAULT.
- `mem_ack` while `mem_req`=0 is ignored: no effect, no fault.
- Legality check, on each edge in TRACK/MEM_WAIT:
  - count must equal the previously sampled count, or (previous+1) mod NUM_PHASES.
  - count >= NUM_PHASES is always illegal.
  - any count change while in MEM_WAIT is illegal.
  - every violation -> FAULT.
- `retired` increments by 1 on each sampled transition from NUM_PHASES-1 to 0. It wraps 0xFFFF -> 0x0000.
- Timeout counter (4 bits at the default): clears on MEM_WAIT entry and increments each MEM_WAIT cycle without ack. Reaching MEM_TIMEOUT -> FAULT.
- In FAULT: all strobes 0, `mem_req`=0, `hold`=1, `fault`=1. Only `rst_n` exits FAULT.
- Simultaneous `enable` fall and `mem_ack`: enable wins; go to IDLE and do not count the ack.
- Simultaneous violation and `mem_ack`: FAULT wins.

## Timing
- Reset values: state IDLE, all strobes 0, `mem_req` 0, `retired` 0, timeout 0, `fault` 0. `hold` = 0 because state is IDLE.
- Strobe latency: the strobe for phase p is high in the cycle after `count`=p is sampled. It stays high while `count` holds p, and is never high for more than one phase at a time.
- `mem_req` rises one cycle after memory-phase entry is sampled. It falls one cycle after the `mem_ack` edge.
- `hold` is combinational, so the state machine sees the stall in the same cycle `count` enters a memory phase. `hold` falls combinationally in the ack cycle, so the state machine advances on that edge.
- Fetch phase minimum duration: 2 cycles (request issued, then ack on the earliest possible cycle).
- `rst_n` assertion mid-handshake drops `mem_req` and strobes immediately (asynchronously).

## Structure
- Shared `s_machine_pkg`:
  - phase encoding constants: PH_FETCH=0, PH_DECODE=1, PH_EXECUTE=2, PH_WRITEBACK=3.
  - decoder state enum.
  - default NUM_PHASES and MEM_TIMEOUT.
- One natural sub-module: `mem_timeout_counter` (clear/increment/expired), reusable by other memory clients.

## Test plan
- Reset then `enable`=1, `count` 0 with `mem_ack` on the 2nd cycle, then 1, 2, 3 with `mem_ack` -> strobes fetch, decode, execute, writeback each one cycle late; `mem_req` pulses twice; `retired`=1 after the 3->0 transition.
- Fetch with no `mem_ack` for 15 cycles -> `fault`=1, `hold`=1, `mem_req`=0; stays until `rst_n`=0.
- Legal run, then `count` jumps 1->3 -> FAULT on the next edge. Separate case `count`=5 -> FAULT.
- `mem_ack` pulse while in TRACK at `count`=1 -> no state change, no fault, `retired` unchanged.
- Preload 65535 retirements (force `retired`=0xFFFF), one more instruction -> `retired`=0x0000.
- `rst_n` low while `mem_req`=1 in MEM_WAIT -> all outputs at reset values before the next edge; after release, `enable`=1, `count`=0 restarts cleanly.

Source files
------------

// File: rtl/s_machine_pkg.sv
// Shared definitions for the S-Machine sequencing interface: phase numbering,
// decoder states and default sizing.
package s_machine_pkg;

    localparam int PH_FETCH     = 0;
    localparam int PH_DECODE    = 1;
    localparam int PH_EXECUTE   = 2;
    localparam int PH_WRITEBACK = 3;

    localparam int DEF_NUM_PHASES  = 4;
    localparam int DEF_MEM_TIMEOUT = 15;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_TRACK,
        DEC_MEM_WAIT,
        DEC_FAULT
    } dec_state_t;

    // Fetch (first) and writeback (last) phases are the ones that talk to memory.
    function automatic logic is_mem_phase(input logic [7:0] cnt, input int num_phases);
        return (cnt == 8'd0) || (int'(cnt) == num_phases - 1);
    endfunction

endpackage

// File: rtl/phase_decoder_if.sv
// Sequencing bus between the S-Machine (master) and the phase decoder (slave).
interface phase_decoder_if;

    logic        enable;
    logic [7:0]  count;
    logic        mem_ack;
    logic        fetch_en;
    logic        decode_en;
    logic        execute_en;
    logic        writeback_en;
    logic        mem_req;
    logic        hold;
    logic [15:0] retired;
    logic        fault;

    modport master (
        output enable, count, mem_ack,
        input  fetch_en, decode_en, execute_en, writeback_en,
        input  mem_req, hold, retired, fault
    );

    modport slave (
        input  enable, count, mem_ack,
        output fetch_en, decode_en, execute_en, writeback_en,
        output mem_req, hold, retired, fault
    );

endinterface

// File: rtl/phase_decoder_mem_timeout_counter.sv
// Watchdog for an outstanding memory request; expired pulses on the increment
// that would bring the count up to LIMIT.
module mem_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = inc && !clear && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/phase_decoder.sv
// Decodes the S-Machine phase count into registered strobes, runs the fetch and
// writeback memory handshake, checks the count sequence and counts retirements.
module phase_decoder
    import s_machine_pkg::*;
#(
    parameter int NUM_PHASES  = DEF_NUM_PHASES,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    phase_decoder_if.slave   bus
);

    localparam logic [7:0] LAST_PHASE = 8'(NUM_PHASES - 1);

    dec_state_t  state, state_next;
    logic [7:0]  prev_count;
    logic [3:0]  strobe, strobe_next;
    logic        mem_req_q, mem_req_next;
    logic [15:0] retired_q;
    logic        retire;
    logic        mem_phase, count_same, count_step, count_legal;
    logic        tmo_clear, tmo_inc, tmo_expired;

    assign mem_phase   = is_mem_phase(bus.count, NUM_PHASES);
    assign count_same  = (bus.count == prev_count);
    assign count_step  = (bus.count == ((prev_count == LAST_PHASE) ? 8'd0 : prev_count + 8'd1));
    assign count_legal = (int'(bus.count) < NUM_PHASES) && (count_same || count_step);

    // The watchdog only runs inside MEM_WAIT, so it is always zero on entry.
    assign tmo_clear = (state != DEC_MEM_WAIT);
    assign tmo_inc   = (state == DEC_MEM_WAIT) && bus.enable && count_same && !bus.mem_ack;

    mem_timeout_counter #(
        .LIMIT   (MEM_TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    always_comb begin
        state_next   = state;
        mem_req_next = mem_req_q;
        retire       = 1'b0;
        strobe_next  = '0;

        unique case (state)
            DEC_IDLE: begin
                // Starting at count 0 is already the first fetch cycle, so
                // the request goes out straight away.
                if (bus.enable) begin
                    if (bus.count == 8'd0) begin
                        state_next   = DEC_MEM_WAIT;
                        mem_req_next = 1'b1;
                    end else begin
                        state_next = DEC_FAULT;
                    end
                end
            end
            DEC_TRACK: begin
                if (!bus.enable) begin
                    state_next = DEC_IDLE;
                end else if (!count_legal) begin
                    state_next = DEC_FAULT;
                end else begin
                    retire = (prev_count == LAST_PHASE) && (bus.count == 8'd0);
                    if (!count_same && mem_phase) begin
                        state_next   = DEC_MEM_WAIT;
                        mem_req_next = 1'b1;
                    end
                end
            end
            DEC_MEM_WAIT: begin
                if (!bus.enable) begin
                    state_next = DEC_IDLE;
                end else if (!count_same) begin
                    state_next = DEC_FAULT;
                end else if (bus.mem_ack) begin
                    state_next   = DEC_TRACK;
                    mem_req_next = 1'b0;
                end else if (tmo_expired) begin
                    state_next = DEC_FAULT;
                end
            end
            default: state_next = DEC_FAULT;
        endcase

        if (state_next == DEC_IDLE || state_next == DEC_FAULT) begin
            mem_req_next = 1'b0;
        end

        if (state_next == DEC_TRACK || state_next == DEC_MEM_WAIT) begin
            strobe_next[PH_FETCH]     = (bus.count == 8'(PH_FETCH));
            strobe_next[PH_DECODE]    = (bus.count == 8'(PH_DECODE));
            strobe_next[PH_EXECUTE]   = (bus.count == 8'(PH_EXECUTE));
            strobe_next[PH_WRITEBACK] = (bus.count == LAST_PHASE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DEC_IDLE;
            strobe    <= '0;
            mem_req_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state     <= state_next;
            strobe    <= strobe_next;
            mem_req_q <= mem_req_next;
            retired_q <= retired_q + 16'(retire);
        end
    end

    // Only consulted in TRACK/MEM_WAIT, which are always entered after a sample.
    always_ff @(posedge clk) begin
        prev_count <= bus.count;
    end

    assign bus.fetch_en     = strobe[PH_FETCH];
    assign bus.decode_en    = strobe[PH_DECODE];
    assign bus.execute_en   = strobe[PH_EXECUTE];
    assign bus.writeback_en = strobe[PH_WRITEBACK];
    assign bus.mem_req      = mem_req_q;
    assign bus.retired      = retired_q;
    assign bus.fault        = (state == DEC_FAULT);
    assign bus.hold         = (bus.enable && mem_phase && !(mem_req_q && bus.mem_ack)
                               && state != DEC_IDLE) || (state == DEC_FAULT);

endmodule

// File: tb/tb_phase_decoder.sv
// Directed and randomized checks of phase_decoder against a behavioural model.
module tb_phase_decoder;

    localparam int NP  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n;

    phase_decoder_if bus();

    phase_decoder #(
        .NUM_PHASES  (NP),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_running, m_waiting, m_faulted;
    int m_last, m_retired, m_wait, m_phase;

    function automatic bit mem_ph(input int c);
        return (c == 0) || (c == NP - 1);
    endfunction

    function automatic bit model_hold(input bit en, input int c, input bit ack);
        return m_faulted || (en && m_running && mem_ph(c) && !(m_waiting && ack));
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_waiting = 0; m_faulted = 0;
        m_last = 0; m_retired = 0; m_wait = 0; m_phase = -1;
    endtask

    task automatic model_fault();
        m_faulted = 1; m_running = 0; m_waiting = 0; m_phase = -1;
    endtask

    task automatic model_edge(input bit en, input int c, input bit ack);
        if (m_faulted) begin
        end else if (!en) begin
            m_running = 0; m_waiting = 0; m_phase = -1;
        end else if (!m_running) begin
            if (c == 0) begin
                m_running = 1; m_waiting = 1; m_wait = 0; m_phase = 0;
            end else begin
                model_fault();
            end
        end else if (m_waiting) begin
            if (c != m_last) model_fault();
            else if (ack) m_waiting = 0;
            else begin
                m_wait++;
                if (m_wait >= TMO) model_fault();
            end
        end else begin
            if (c >= NP || (c != m_last && c != (m_last + 1) % NP)) begin
                model_fault();
            end else begin
                if (m_last == NP - 1 && c == 0) m_retired = (m_retired + 1) % 65536;
                if (c != m_last && mem_ph(c)) begin
                    m_waiting = 1; m_wait = 0;
                end
                m_phase = c;
            end
        end
        m_last = c;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_str;
        exp_str = (m_phase >= 0) ? 4'(1 << m_phase) : 4'b0;
        check({tag, ":strobes"},
              {12'b0, bus.writeback_en, bus.execute_en, bus.decode_en, bus.fetch_en},
              {12'b0, exp_str});
        check({tag, ":mem_req"}, 16'(bus.mem_req), 16'(m_waiting));
        check({tag, ":retired"}, bus.retired, 16'(m_retired));
        check({tag, ":fault"},   16'(bus.fault), 16'(m_faulted));
    endtask

    // Called at a falling edge: drive, check hold, clock, check registered outputs.
    task automatic step(input bit en, input int c, input bit ack, input string tag);
        bus.enable  = en;
        bus.count   = 8'(c);
        bus.mem_ack = ack;
        #1;
        check({tag, ":hold"}, 16'(bus.hold), 16'(model_hold(en, c, ack)));
        @(posedge clk);
        model_edge(en, c, ack);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        check({tag, ":hold"}, 16'(bus.hold), 16'd0);
        bus.enable  = 1'b0;
        bus.count   = 8'd0;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input string tag);
        step(1, 0, 0, tag); step(1, 0, 1, tag); step(1, 1, 0, tag);
        step(1, 2, 0, tag); step(1, 3, 0, tag); step(1, 3, 1, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sm_count, fault_age, c;
        bit en, ack, h, was_running;

        bus.enable = 1'b0; bus.count = 8'd0; bus.mem_ack = 1'b0;
        @(negedge clk);
        do_reset("reset");

        // One full instruction, then the retiring 3->0 step.
        step(1, 0, 0, "i_fetch");
        check("i_fetch_req", 16'(bus.mem_req), 16'd1);
        check("i_fetch_en",  16'(bus.fetch_en), 16'd1);
        step(1, 0, 1, "i_fetch_ack");
        check("i_ack_req", 16'(bus.mem_req), 16'd0);
        step(1, 1, 0, "i_decode");
        check("i_decode_en", 16'(bus.decode_en), 16'd1);
        step(1, 2, 0, "i_execute");
        check("i_execute_en", 16'(bus.execute_en), 16'd1);
        step(1, 3, 0, "i_wb");
        check("i_wb_en",  16'(bus.writeback_en), 16'd1);
        check("i_wb_req", 16'(bus.mem_req), 16'd1);
        step(1, 3, 1, "i_wb_ack");
        step(1, 0, 0, "i_retire");
        check("i_retired", bus.retired, 16'd1);
        step(1, 0, 1, "i_fetch2_ack");

        // Stray acknowledge with no request outstanding.
        step(1, 1, 1, "spur_ack");
        check("spur_fault",   16'(bus.fault), 16'd0);
        check("spur_retired", bus.retired, 16'd1);
        check("spur_decode",  16'(bus.decode_en), 16'd1);
        step(1, 1, 0, "spur_after");
        step(0, 1, 0, "disable");
        check("disable_retired", bus.retired, 16'd1);

        // Memory never answers.
        do_reset("tmo_reset");
        step(1, 0, 0, "tmo_entry");
        for (int i = 0; i < TMO - 1; i++) step(1, 0, 0, "tmo_wait");
        check("tmo_not_yet", 16'(bus.fault), 16'd0);
        check("tmo_req_up",  16'(bus.mem_req), 16'd1);
        step(1, 0, 0, "tmo_expire");
        check("tmo_fault", 16'(bus.fault), 16'd1);
        check("tmo_req",   16'(bus.mem_req), 16'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, "tmo_sticky");
        check("tmo_sticky_fault", 16'(bus.fault), 16'd1);
        check("tmo_sticky_hold",  16'(bus.hold), 16'd1);

        // Illegal jumps.
        do_reset("jump_reset");
        step(1, 0, 0, "jump"); step(1, 0, 1, "jump"); step(1, 1, 0, "jump");
        step(1, 3, 0, "jump_1_3");
        check("jump_fault", 16'(bus.fault), 16'd1);
        do_reset("range_reset");
        step(1, 0, 0, "range"); step(1, 0, 1, "range");
        step(1, 5, 0, "range_5");
        check("range_fault", 16'(bus.fault), 16'd1);

        // Count moves during a handshake together with ack: fault wins.
        do_reset("viol_reset");
        step(1, 0, 0, "viol");
        step(1, 1, 1, "viol_ack");
        check("viol_fault", 16'(bus.fault), 16'd1);

        // Enable drops together with ack: enable wins.
        do_reset("enfall_reset");
        step(1, 0, 0, "enfall");
        step(0, 0, 1, "enfall_ack");
        check("enfall_fault", 16'(bus.fault), 16'd0);
        check("enfall_req",   16'(bus.mem_req), 16'd0);
        step(1, 0, 0, "enfall_restart");
        check("enfall_restart_req", 16'(bus.mem_req), 16'd1);

        // Retirement counter wrap.
        do_reset("wrap_reset");
        force dut.retired_q = 16'hFFFF;
        m_retired = 65535;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_q;
        check("wrap_preload", bus.retired, 16'hFFFF);
        run_instr("wrap");
        step(1, 0, 0, "wrap_retire");
        check("wrap_zero", bus.retired, 16'h0000);

        // Reset in the middle of a handshake, then a clean restart.
        do_reset("mid_reset0");
        step(1, 0, 0, "mid_req");
        check("mid_req_up", 16'(bus.mem_req), 16'd1);
        rst_n = 1'b0;
        #1;
        check("mid_async_req",   16'(bus.mem_req), 16'd0);
        check("mid_async_fetch", 16'(bus.fetch_en), 16'd0);
        check("mid_async_hold",  16'(bus.hold), 16'd0);
        do_reset("mid_reset");
        run_instr("mid_restart");
        step(1, 0, 0, "mid_retire");
        check("mid_retired", bus.retired, 16'd1);

        // Randomized sequencing against the model.
        do_reset("rnd_reset");
        sm_count  = 0;
        fault_age = 0;
        for (int it = 0; it < 2500; it++) begin
            en  = ($urandom_range(0, 99) < 97);
            ack = m_waiting ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 10);
            c   = sm_count;
            h   = model_hold(en, c, ack);
            was_running = m_running;
            step(en, c, ack, "rnd");
            if (m_faulted) begin
                fault_age++;
                if (fault_age > 3) begin
                    do_reset("rnd_refault");
                    sm_count  = 0;
                    fault_age = 0;
                end
            end else if (!en || !m_running) begin
                sm_count = 0;
            end else if (was_running && !h) begin
                if (mem_ph(c) || $urandom_range(0, 99) < 75) sm_count = (sm_count + 1) % NP;
            end
            if (!m_faulted && $urandom_range(0, 199) == 0) sm_count = $urandom_range(0, 7);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
